// File: rtl/display_scan_mux_pkg.sv
// display_scan_mux_pkg: shared state encodings, digit constants and nibble helpers
package display_scan_mux_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GUARD = 2'd1, DRIVE = 2'd2} state_t;
    localparam int NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = 4'hF;
    function automatic logic [3:0] nibble_at(input logic [15:0] v, input logic [1:0] i);
        return v[{i, 2'b00} +: 4];
    endfunction
    // A digit above 0 goes dark when it and every digit to its left are zero
    function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [15:0] v, input logic [1:0] i, input logic blz);
        return (blz && i != 2'd0 && (v >> {i, 2'b00}) == 16'd0) ? DIGIT_OFF : ~(4'b0001 << i);
    endfunction
endpackage

// File: rtl/display_scan_mux_if.sv
// display_scan_mux_if: control inputs and scan outputs of the display multiplexer
interface display_scan_mux_if;
    import display_scan_mux_pkg::*;
    logic                  enable;
    logic [15:0]           value_in;
    logic                  load;
    logic                  blank_lz;
    logic [3:0]            nibble_out;
    logic [NUM_DIGITS-1:0] digit_en_n;
    logic                  frame_tick;
    logic                  pending;
    modport master (output enable, value_in, load, blank_lz, input nibble_out, digit_en_n, frame_tick, pending);
    modport slave (input enable, value_in, load, blank_lz, output nibble_out, digit_en_n, frame_tick, pending);
endinterface

// File: rtl/display_scan_mux_scan_prescaler.sv
// scan_prescaler: loadable down-counter with clear, holding at zero with terminal-count flag
module scan_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic         tc
);
    logic [W-1:0] count;
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else count <= clr ? '0 : ld ? ld_val : tc ? count : count - W'(1);
    assign tc = count == '0;
endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: scans a double-buffered 4-nibble value onto one 7-segment bus
// with a blanking guard before each digit and optional leading-zero blanking.
module display_scan_mux
    import display_scan_mux_pkg::*;
#(
    parameter int PRESCALE  = 50000,
    parameter int GUARD_CYC = 16
) (
    input logic              clk,
    input logic              reset,
    display_scan_mux_if.slave bus
);
    localparam int CW = $clog2(PRESCALE > GUARD_CYC ? PRESCALE : GUARD_CYC);
    state_t        state;
    logic [1:0]    index;
    logic [15:0]   shadow, disp, next_disp;
    logic          tc, clr, ld, boundary;
    logic [CW-1:0] ld_val;
    scan_prescaler #(.W(CW)) u_prescaler (
        .clk(clk), .reset(reset), .clr(clr), .ld(ld), .ld_val(ld_val), .tc(tc)
    );
    // The counter reloads on every state entry, so one counter times both intervals
    always_comb begin
        clr       = !bus.enable;
        ld        = bus.enable && (state == IDLE || tc);
        ld_val    = state == GUARD ? CW'(PRESCALE - 1) : CW'(GUARD_CYC - 1);
        boundary  = bus.enable && state == DRIVE && tc && index == 2'd3;
        next_disp = boundary && bus.pending ? shadow : disp;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            index          <= '0;
            shadow         <= '0;
            disp           <= '0;
            bus.nibble_out <= '0;
            bus.digit_en_n <= DIGIT_OFF;
            bus.frame_tick <= 1'b0;
            bus.pending    <= 1'b0;
        end else begin
            bus.frame_tick <= boundary;
            disp           <= next_disp;
            if (bus.load) begin
                shadow      <= bus.value_in;
                bus.pending <= 1'b1;
            end else if (boundary) bus.pending <= 1'b0;
            if (!bus.enable) begin
                state          <= IDLE;
                index          <= '0;
                bus.digit_en_n <= DIGIT_OFF;
            end else case (state)
                IDLE: begin
                    state          <= GUARD;
                    bus.nibble_out <= nibble_at(disp, index);
                end
                GUARD: if (tc) begin
                    state          <= DRIVE;
                    bus.digit_en_n <= digit_enable(disp, index, bus.blank_lz);
                end
                // Nibble changes at guard entry so the decoders settle while all digits are dark
                DRIVE: if (tc) begin
                    state          <= GUARD;
                    index          <= index + 2'd1;
                    bus.digit_en_n <= DIGIT_OFF;
                    bus.nibble_out <= nibble_at(next_disp, index + 2'd1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: directed scenario checks of display_scan_mux with PRESCALE=4, GUARD_CYC=1
module tb_display_scan_mux;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    bit   seen;
    display_scan_mux_if bus();
    display_scan_mux #(.PRESCALE(4), .GUARD_CYC(1)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    // One frame is 20 samples: k%5==0 is the guard cycle, k/5 is the digit
    function automatic logic [3:0] exp_en(input logic [15:0] v, input int k, input logic blz);
        int d = k / 5;
        if (k % 5 == 0) return 4'hF;
        if (blz && d != 0 && (v >> (4 * d)) == 16'd0) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [3:0] exp_nib(input logic [15:0] v, input int k);
        return v[4 * (k / 5) +: 4];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_tick(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = bus.frame_tick;
        end
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (bus.digit_en_n !== 4'hF) begin fails++; $display("FAIL reset_en got=%b exp=1111", bus.digit_en_n); end
        tests++;
        if (bus.nibble_out !== 4'h0) begin fails++; $display("FAIL reset_nib got=%h exp=0", bus.nibble_out); end
        tests++;
        if (bus.frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick got=%b exp=0", bus.frame_tick); end
        tests++;
        if (bus.pending !== 1'b0) begin fails++; $display("FAIL reset_pending got=%b exp=0", bus.pending); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_scan();
        bus.enable = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            tests++;
            if (bus.digit_en_n !== exp_en(16'h0, k, 1'b0) || bus.nibble_out !== 4'h0 || bus.frame_tick !== 1'b0) begin
                fails++;
                $display("FAIL scan k=%0d en=%b nib=%h tick=%b exp en=%b nib=0 tick=0", k, bus.digit_en_n, bus.nibble_out, bus.frame_tick, exp_en(16'h0, k, 1'b0));
            end
        end
        tick();
        tests++;
        if (bus.frame_tick !== 1'b1) begin fails++; $display("FAIL scan_tick got=%b exp=1", bus.frame_tick); end
    endtask

    task automatic test_load();
        ticks(7);
        bus.value_in = 16'h1234;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        tests++;
        if (bus.pending !== 1'b1 || bus.nibble_out !== 4'h0) begin
            fails++;
            $display("FAIL load_pending pend=%b nib=%h exp pend=1 nib=0", bus.pending, bus.nibble_out);
        end
        wait_tick(seen);
        tests++;
        if (!seen || bus.pending !== 1'b0) begin fails++; $display("FAIL load_commit seen=%b pend=%b exp seen=1 pend=0", seen, bus.pending); end
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            tests++;
            if (bus.digit_en_n !== exp_en(16'h1234, k, 1'b0) || bus.nibble_out !== exp_nib(16'h1234, k)) begin
                fails++;
                $display("FAIL load_frame k=%0d en=%b nib=%h exp en=%b nib=%h", k, bus.digit_en_n, bus.nibble_out, exp_en(16'h1234, k, 1'b0), exp_nib(16'h1234, k));
            end
        end
    endtask

    task automatic test_two_loads();
        ticks(3);
        bus.value_in = 16'hAAAA;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        ticks(3);
        bus.value_in = 16'h00F0;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.blank_lz = 1'b1;
        tests++;
        if (bus.pending !== 1'b1 || bus.nibble_out !== 4'h3) begin
            fails++;
            $display("FAIL two_loads_hold pend=%b nib=%h exp pend=1 nib=3", bus.pending, bus.nibble_out);
        end
        wait_tick(seen);
        tests++;
        if (!seen) begin fails++; $display("FAIL two_loads_tick seen=0 exp=1"); end
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            tests++;
            if (bus.digit_en_n !== exp_en(16'h00F0, k, 1'b1) || bus.nibble_out !== exp_nib(16'h00F0, k)) begin
                fails++;
                $display("FAIL blank_frame k=%0d en=%b nib=%h exp en=%b nib=%h", k, bus.digit_en_n, bus.nibble_out, exp_en(16'h00F0, k, 1'b1), exp_nib(16'h00F0, k));
            end
        end
    endtask

    task automatic test_load_on_tick();
        ticks(4);
        bus.value_in = 16'h0789;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        ticks(15);
        bus.value_in = 16'h5555;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        tests++;
        if (bus.frame_tick !== 1'b1 || bus.pending !== 1'b1) begin
            fails++;
            $display("FAIL tick_load tick=%b pend=%b exp tick=1 pend=1", bus.frame_tick, bus.pending);
        end
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            tests++;
            if (bus.digit_en_n !== exp_en(16'h0789, k, 1'b1) || bus.nibble_out !== exp_nib(16'h0789, k)) begin
                fails++;
                $display("FAIL old_shadow_frame k=%0d en=%b nib=%h exp en=%b nib=%h", k, bus.digit_en_n, bus.nibble_out, exp_en(16'h0789, k, 1'b1), exp_nib(16'h0789, k));
            end
        end
        tick();
        tests++;
        if (bus.frame_tick !== 1'b1 || bus.pending !== 1'b0) begin
            fails++;
            $display("FAIL second_commit tick=%b pend=%b exp tick=1 pend=0", bus.frame_tick, bus.pending);
        end
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            tests++;
            if (bus.digit_en_n !== exp_en(16'h5555, k, 1'b1) || bus.nibble_out !== exp_nib(16'h5555, k)) begin
                fails++;
                $display("FAIL new_shadow_frame k=%0d en=%b nib=%h exp en=%b nib=%h", k, bus.digit_en_n, bus.nibble_out, exp_en(16'h5555, k, 1'b1), exp_nib(16'h5555, k));
            end
        end
    endtask

    task automatic test_enable_drop();
        ticks(12);
        tests++;
        if (bus.digit_en_n !== 4'b1011) begin fails++; $display("FAIL drive_digit2 got=%b exp=1011", bus.digit_en_n); end
        bus.enable = 1'b0;
        tick();
        tests++;
        if (bus.digit_en_n !== 4'hF || bus.frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL disable en=%b tick=%b exp en=1111 tick=0", bus.digit_en_n, bus.frame_tick);
        end
        ticks(3);
        tests++;
        if (bus.digit_en_n !== 4'hF) begin fails++; $display("FAIL idle_dark got=%b exp=1111", bus.digit_en_n); end
        bus.enable = 1'b1;
        tick();
        tests++;
        if (bus.digit_en_n !== 4'hF || bus.nibble_out !== 4'h5 || bus.frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL restart_guard en=%b nib=%h tick=%b exp en=1111 nib=5 tick=0", bus.digit_en_n, bus.nibble_out, bus.frame_tick);
        end
        tick();
        tests++;
        if (bus.digit_en_n !== 4'b1110) begin fails++; $display("FAIL restart_digit0 got=%b exp=1110", bus.digit_en_n); end
        ticks(4);
        tests++;
        if (bus.digit_en_n !== 4'hF || bus.nibble_out !== 4'h5) begin
            fails++;
            $display("FAIL restart_guard1 en=%b nib=%h exp en=1111 nib=5", bus.digit_en_n, bus.nibble_out);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.value_in = 16'h1111;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        tests++;
        if (bus.pending !== 1'b1 || bus.digit_en_n !== 4'b1101) begin
            fails++;
            $display("FAIL pre_reset pend=%b en=%b exp pend=1 en=1101", bus.pending, bus.digit_en_n);
        end
        reset = 1'b1;
        #2;
        tests++;
        if (bus.digit_en_n !== 4'hF || bus.pending !== 1'b0 || bus.nibble_out !== 4'h0 || bus.frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL async_reset en=%b pend=%b nib=%h tick=%b exp en=1111 pend=0 nib=0 tick=0", bus.digit_en_n, bus.pending, bus.nibble_out, bus.frame_tick);
        end
        #1;
        reset = 1'b0;
        tick();
        tests++;
        if (bus.digit_en_n !== 4'hF || bus.nibble_out !== 4'h0) begin
            fails++;
            $display("FAIL post_reset_guard en=%b nib=%h exp en=1111 nib=0", bus.digit_en_n, bus.nibble_out);
        end
        tick();
        tests++;
        if (bus.digit_en_n !== 4'b1110 || bus.nibble_out !== 4'h0) begin
            fails++;
            $display("FAIL post_reset_digit0 en=%b nib=%h exp en=1110 nib=0", bus.digit_en_n, bus.nibble_out);
        end
        wait_tick(seen);
        tests++;
        if (!seen || bus.pending !== 1'b0 || bus.nibble_out !== 4'h0) begin
            fails++;
            $display("FAIL post_reset_frame seen=%b pend=%b nib=%h exp seen=1 pend=0 nib=0", seen, bus.pending, bus.nibble_out);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.load = 1'b0;
        bus.value_in = 16'h0;
        bus.blank_lz = 1'b0;
        test_reset();
        test_scan();
        test_load();
        test_two_loads();
        test_load_on_tick();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
